// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: controller states and the
// transfer-size encoding that memory's mov_sz input also uses.
package lsu_pkg;

  // Controller states: one store state, up to three read states, and a
  // response state that waits for the consumer.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    RESP = 3'd5
  } lsu_state_e;

  // Transfer size encoding; it must agree with the memory-side mov_sz decode.
  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Widen a loaded byte to 16 bits, copying bit 7 upward when sign_en is set.
  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sign_en);
    return {{8{sign_en & b[7]}}, b};
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store initiator between the execute stage and a byte-addressed data
// memory. Each request is handled on its own. A word load takes two
// sequential byte reads, because the memory returns only one byte per read.
// The two bytes are joined little-endian. Every mem_* output comes from a
// register, so no request input reaches the memory port in the same cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_size,
  input  logic                req_signed,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [15:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [15:0]         resp_rdata,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [15:0]         mem_in,
  output logic                mem_mov_sz,
  output logic                mem_write_en,
  input  logic [15:0]         mem_out
);

  lsu_state_e          state_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic                size_q;
  logic                signed_q;
  logic [7:0]          lo_q;
  logic [15:0]         resp_rdata_q;
  logic [ADDR_LEN-1:0] mem_addr_q;
  logic [15:0]         mem_in_q;
  logic                mem_mov_sz_q;
  logic                mem_write_en_q;

  // The memory returns one byte per read, so its upper lane is never read.
  logic [7:0] unused_mem_hi;
  assign unused_mem_hi = mem_out[15:8];

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = resp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_in       = mem_in_q;
  assign mem_mov_sz   = mem_mov_sz_q;
  assign mem_write_en = mem_write_en_q;

  // Controller: accept a request in IDLE, then sequence the memory port.
  // The memory port values are loaded one edge early so that each one is
  // already stable while its state is current. The async reset drops the
  // write strobe at once, which stops a store that is still in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      size_q         <= SZ_BYTE;
      signed_q       <= 1'b0;
      lo_q           <= 8'h00;
      resp_rdata_q   <= 16'h0000;
      mem_addr_q     <= '0;
      mem_in_q       <= 16'h0000;
      mem_mov_sz_q   <= SZ_BYTE;
      mem_write_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            signed_q   <= req_signed;
            mem_addr_q <= req_addr;
            if (req_write) begin
              mem_in_q       <= req_wdata;
              mem_mov_sz_q   <= req_size;
              mem_write_en_q <= 1'b1;
              state_q        <= WR;
            end else begin
              state_q <= RD0;
            end
          end
        end
        WR: begin
          mem_write_en_q <= 1'b0;
          resp_rdata_q   <= 16'h0000;
          state_q        <= RESP;
        end
        RD0: begin
          mem_addr_q <= addr_q + ADDR_LEN'(1);
          state_q    <= RD1;
        end
        RD1: begin
          lo_q <= mem_out[7:0];
          if (size_q == SZ_WORD) begin
            state_q <= RD2;
          end else begin
            resp_rdata_q <= extend_byte(mem_out[7:0], signed_q);
            state_q      <= RESP;
          end
        end
        RD2: begin
          resp_rdata_q <= {mem_out[7:0], lo_q};
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
